// File: rtl/dcache_responder_pkg.sv
// Shared core definitions for the data-cache responder: geometry defaults and FSM state type.
package dcache_responder_pkg;

  localparam int unsigned DCACHE_NR_LINES = 64;
  localparam int unsigned CACHELINE_SIZE  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StDrain,
    StRefillReq,
    StRefillWait,
    StResp
  } dcache_state_t;

endpackage

// File: rtl/dcache_ports_if.sv
// Load/store port bundle between a core and its data cache.
interface dcache_ports_if;
  logic [63:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [63:0] load_a_addr;
  logic        load_a_valid;
  logic        load_a_ready;
  logic [63:0] load_d_data;
  logic        load_d_valid;

  modport responder (
    input  waddr, wdata, wmask, wvalid, load_a_addr, load_a_valid,
    output wready, load_a_ready, load_d_data, load_d_valid
  );

  modport requester (
    output waddr, wdata, wmask, wvalid, load_a_addr, load_a_valid,
    input  wready, load_a_ready, load_d_data, load_d_valid
  );
endinterface

// File: rtl/dcache_line_ram.sv
// Dword-wide data array: one byte-masked write port, one registered read port.
// A same-cycle write to the read address is forwarded into the read data (write-first).
module dcache_line_ram #(
  parameter int unsigned Words = 512,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wmask,
  input  logic [AddrW-1:0] raddr,
  output logic [63:0]      rdata
);

  logic [63:0] mem_q [Words];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (we && wmask[b]) begin
        mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we && wmask[b] && (waddr == raddr)) begin
        rdata_q[8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata_q[8*b +: 8] <= mem_q[raddr][8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with a 1-entry write buffer
// and a blocking line refill from backing memory.
module dcache_responder
  import dcache_responder_pkg::*;
#(
  parameter int unsigned NR_LINES   = DCACHE_NR_LINES,
  parameter int unsigned LINE_BYTES = CACHELINE_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  dcache_ports_if.responder        dcache_ports_io,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [63:0]              mem_req_addr,
  output logic [63:0]              mem_req_wdata,
  output logic [7:0]               mem_req_wmask,
  input  logic                     mem_rsp_valid,
  input  logic [63:0]              mem_rsp_rdata
);

  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned IdxW  = $clog2(NR_LINES);
  localparam int unsigned TagW  = 64 - OffW - IdxW;
  localparam int unsigned BeatW = OffW - 3;
  localparam int unsigned Beats = LINE_BYTES / 8;
  localparam int unsigned RamAw = IdxW + BeatW;

  dcache_state_t state_q, state_d;
  logic [NR_LINES-1:0] valid_q;
  logic [TagW-1:0]     tag_q [NR_LINES];
  logic [60:0]         miss_dw_q;
  logic [BeatW-1:0]    beat_q;
  logic                hit_q;
  logic                wbuf_valid_q;
  logic [60:0]         wbuf_dw_q;
  logic [63:0]         wbuf_data_q;
  logic [7:0]          wbuf_mask_q;

  logic [60:0]      ld_dw, st_dw;
  logic [IdxW-1:0]  ld_idx, st_idx, miss_idx;
  logic [TagW-1:0]  ld_tag, st_tag, miss_tag;
  logic             ld_hit, st_hit, load_acc, store_acc;
  logic             refill_beat, last_beat, wbuf_req;
  logic             ram_we;
  logic [RamAw-1:0] ram_waddr, ram_raddr;
  logic [63:0]      ram_wdata, ram_rdata;
  logic [7:0]       ram_wmask;
  logic             unused_addr_bits;

  assign ld_dw    = dcache_ports_io.load_a_addr[63:3];
  assign st_dw    = dcache_ports_io.waddr[63:3];
  assign ld_idx   = ld_dw[BeatW +: IdxW];
  assign st_idx   = st_dw[BeatW +: IdxW];
  assign miss_idx = miss_dw_q[BeatW +: IdxW];
  assign ld_tag   = ld_dw[60 -: TagW];
  assign st_tag   = st_dw[60 -: TagW];
  assign miss_tag = miss_dw_q[60 -: TagW];
  assign unused_addr_bits = ^{dcache_ports_io.load_a_addr[2:0], dcache_ports_io.waddr[2:0]};

  assign ld_hit      = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
  assign st_hit      = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
  assign load_acc    = dcache_ports_io.load_a_valid && dcache_ports_io.load_a_ready;
  assign store_acc   = dcache_ports_io.wvalid && dcache_ports_io.wready;
  assign refill_beat = (state_q == StRefillWait) && mem_rsp_valid;
  assign last_beat   = (beat_q == BeatW'(Beats - 1));
  // The refill owns the memory port; the write buffer waits it out.
  assign wbuf_req    = wbuf_valid_q && (state_q != StRefillReq) && (state_q != StRefillWait);

  assign dcache_ports_io.load_a_ready = !rst && (state_q == StIdle);
  assign dcache_ports_io.wready       = !rst && (state_q == StIdle) && !wbuf_valid_q;
  assign dcache_ports_io.load_d_valid = !rst && (hit_q || (state_q == StResp));
  assign dcache_ports_io.load_d_data  = ram_rdata;

  assign ram_we    = !rst && (refill_beat || (store_acc && st_hit));
  assign ram_waddr = refill_beat ? {miss_idx, beat_q} : st_dw[RamAw-1:0];
  assign ram_wdata = refill_beat ? mem_rsp_rdata : dcache_ports_io.wdata;
  assign ram_wmask = refill_beat ? 8'hFF : dcache_ports_io.wmask;
  assign ram_raddr = (state_q == StIdle) ? ld_dw[RamAw-1:0] : miss_dw_q[RamAw-1:0];

  dcache_line_ram #(
    .Words (NR_LINES * Beats),
    .AddrW (RamAw)
  ) u_line_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .wmask (ram_wmask),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (load_acc && !ld_hit) begin
          state_d = (wbuf_valid_q || store_acc) ? StDrain : StRefillReq;
        end
      end
      StDrain:      if (!wbuf_valid_q || mem_req_ready) state_d = StRefillReq;
      StRefillReq:  if (mem_req_ready) state_d = StRefillWait;
      StRefillWait: if (mem_rsp_valid) state_d = last_beat ? StResp : StRefillReq;
      StResp:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    if (!rst) begin
      if (state_q == StRefillReq) begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {miss_dw_q[60:BeatW], beat_q, 3'b000};
      end else if (wbuf_req) begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {wbuf_dw_q, 3'b000};
        mem_req_wdata = wbuf_data_q;
        mem_req_wmask = wbuf_mask_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      beat_q       <= '0;
      hit_q        <= 1'b0;
      wbuf_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= load_acc && ld_hit;
      if (load_acc && !ld_hit) begin
        miss_dw_q <= ld_dw;
        beat_q    <= '0;
      end
      if (refill_beat) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) valid_q[miss_idx] <= 1'b1;
      end
      if (store_acc) begin
        wbuf_valid_q <= 1'b1;
        wbuf_dw_q    <= st_dw;
        wbuf_data_q  <= dcache_ports_io.wdata;
        wbuf_mask_q  <= dcache_ports_io.wmask;
      end else if (wbuf_req && mem_req_ready) begin
        wbuf_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && refill_beat && last_beat) tag_q[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Randomized self-checking bench: architectural memory model, backing memory model and
// a cache-residency model predict load data, hit latency and memory traffic.
module tb_dcache_responder;
  import dcache_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;

  dcache_ports_if ports();

  dcache_responder dut (
    .clk             (clk),
    .rst             (rst),
    .dcache_ports_io (ports),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wmask   (mem_req_wmask),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_rdata   (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, rsp_given = 0;
  bit hold_mem = 1'b0;
  logic [63:0] last_resp = '0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endfunction

  logic [63:0] back_mem [logic [60:0]];
  logic [63:0] arch_mem [logic [60:0]];

  function automatic logic [63:0] init_val(logic [60:0] dw);
    logic [63:0] a;
    a = {dw, 3'b000};
    return {32'hD0D0_0000 + a[31:0], a[31:0]};
  endfunction
  function automatic logic [63:0] back_rd(logic [60:0] dw);
    return back_mem.exists(dw) ? back_mem[dw] : init_val(dw);
  endfunction
  function automatic logic [63:0] arch_rd(logic [60:0] dw);
    return arch_mem.exists(dw) ? arch_mem[dw] : init_val(dw);
  endfunction
  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  typedef struct { logic [63:0] data; bit hit; int acc_cyc; } resp_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] mask; } wr_t;
  typedef struct { logic [63:0] data; int rdy; } pend_t;
  resp_t       exp_resp[$];
  wr_t         exp_wr[$];
  logic [63:0] exp_rd[$];
  pend_t       pend[$];
  bit          vld [64];
  logic [57:0] line_of [64];

  always @(posedge clk) cyc = cyc + 1;

  // Backing memory: random request backpressure, in-order read responses.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      pend.delete();
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
    end else begin
      mem_req_ready = hold_mem ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (pend.size() > 0 && pend[0].rdy <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = pend[0].data;
        void'(pend.pop_front());
        rsp_given++;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
      end
    end
  end

  bit          req_hold = 1'b0;
  logic [63:0] h_addr, h_data;
  logic [7:0]  h_mask;
  logic        h_we;

  always @(negedge clk) begin
    resp_t       r;
    wr_t         w;
    logic [63:0] base;
    logic [57:0] line;
    logic [5:0]  idx;
    bit          hit;
    if (rst) begin
      chk("reset_outputs", {ports.load_d_valid, mem_req_valid, ports.load_a_ready, ports.wready},
          4'b0000);
      exp_resp.delete();
      exp_rd.delete();
      exp_wr.delete();
      pend.delete();
      arch_mem = back_mem;
      foreach (vld[i]) vld[i] = 1'b0;
      req_hold = 1'b0;
    end else begin
      if (req_hold) begin
        chk("req_hold_ctl", {mem_req_valid, mem_req_we, mem_req_wmask}, {1'b1, h_we, h_mask});
        chk("req_hold_addr", mem_req_addr, h_addr);
        chk("req_hold_wdata", mem_req_wdata, h_data);
      end
      req_hold = mem_req_valid && !mem_req_ready;
      h_addr = mem_req_addr; h_data = mem_req_wdata; h_mask = mem_req_wmask; h_we = mem_req_we;

      if (ports.load_d_valid) begin
        resp_cnt++;
        last_resp = ports.load_d_data;
        if (exp_resp.size() == 0) begin
          chk("spurious_load_d_valid", 1, 0);
        end else begin
          r = exp_resp.pop_front();
          chk("load_data", ports.load_d_data, r.data);
          if (r.hit) chk("hit_latency", cyc - r.acc_cyc, 1);
        end
      end

      if (exp_resp.size() != 0 && !exp_resp[0].hit) chk("ready_while_miss", ports.load_a_ready, 0);

      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          wr_cnt++;
          if (exp_wr.size() == 0) begin
            chk("unexpected_mem_write", 1, 0);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", mem_req_addr, w.addr);
            chk("wr_data", mem_req_wdata, w.data);
            chk("wr_mask", mem_req_wmask, w.mask);
          end
          back_mem[mem_req_addr[63:3]] = merge(back_rd(mem_req_addr[63:3]), mem_req_wdata,
                                               mem_req_wmask);
        end else begin
          rd_cnt++;
          chk("write_before_read", exp_wr.size(), 0);
          if (exp_rd.size() == 0) chk("unexpected_mem_read", 1, 0);
          else chk("rd_addr", mem_req_addr, exp_rd.pop_front());
          pend.push_back('{back_rd(mem_req_addr[63:3]), cyc + 1 + $urandom_range(0, 2)});
        end
      end

      // Store first so a same-cycle load to the same dword sees it.
      if (ports.wvalid && ports.wready) begin
        arch_mem[ports.waddr[63:3]] = merge(arch_rd(ports.waddr[63:3]), ports.wdata, ports.wmask);
        exp_wr.push_back('{{ports.waddr[63:3], 3'b000}, ports.wdata, ports.wmask});
      end
      if (ports.load_a_valid && ports.load_a_ready) begin
        line = ports.load_a_addr[63:6];
        idx  = line[5:0];
        hit  = vld[idx] && (line_of[idx] == line);
        exp_resp.push_back('{arch_rd(ports.load_a_addr[63:3]), hit, cyc});
        if (!hit) begin
          base = {line, 6'b0};
          for (int k = 0; k < 8; k++) exp_rd.push_back(base + 64'(8 * k));
          vld[idx] = 1'b1;
          line_of[idx] = line;
        end
      end
    end
  end

  task automatic issue(bit do_ld, logic [63:0] la, bit do_st, logic [63:0] sa,
                       logic [63:0] sd, logic [7:0] sm);
    int n = 0;
    @(negedge clk);
    while (!((!do_ld || ports.load_a_ready) && (!do_st || ports.wready))) begin
      n++;
      if (n > 500) begin
        chk("issue_ready_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    ports.load_a_valid = do_ld;
    ports.load_a_addr  = la;
    ports.wvalid       = do_st;
    ports.waddr        = sa;
    ports.wdata        = sd;
    ports.wmask        = sm;
    @(posedge clk); #1;
    ports.load_a_valid = 1'b0;
    ports.wvalid       = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    @(negedge clk);
    while (exp_resp.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 || mem_req_valid) begin
      n++;
      if (n > 2000) begin
        chk("quiesce_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'h1;
      1:       t = 64'h2;
      2:       t = 64'h5;
      default: t = 64'h7;
    endcase
    return (t << 12) | (64'($urandom_range(0, 3)) << 6) | (64'($urandom_range(0, 7)) << 3)
           | 64'($urandom_range(0, 7));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int r0, w0, c0, g0, n, kind;
    logic [63:0] la, sa;
    ports.load_a_valid = 1'b0;
    ports.wvalid       = 1'b0;
    ports.load_a_addr  = '0;
    ports.waddr        = '0;
    ports.wdata        = '0;
    ports.wmask        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {ports.load_a_ready, ports.wready, ports.load_d_valid}, 3'b110);

    // Cold miss: 8 reads of the line, one response.
    r0 = rd_cnt; c0 = resp_cnt;
    issue(1, 64'h1000, 0, '0, '0, '0);
    wait_quiet();
    chk("cold_reads", rd_cnt - r0, 8);
    chk("cold_resps", resp_cnt - c0, 1);
    chk("cold_data", last_resp, 64'hD0D0_1000_0000_1000);

    // Hit in the refilled line.
    r0 = rd_cnt;
    issue(1, 64'h1008, 0, '0, '0, '0);
    wait_quiet();
    chk("hit_no_read", rd_cnt - r0, 0);
    chk("hit_data", last_resp, 64'hD0D0_1008_0000_1008);

    // Store hit on the upper word, then reload.
    w0 = wr_cnt;
    issue(0, '0, 1, 64'h1004, 64'hAABB_CCDD_0000_0000, 8'hF0);
    wait_quiet();
    chk("store_one_write", wr_cnt - w0, 1);
    issue(1, 64'h1000, 0, '0, '0, '0);
    wait_quiet();
    chk("store_hit_data", last_resp, 64'hAABB_CCDD_0000_1000);

    // Same-cycle load and store to one dword.
    issue(1, 64'h1000, 1, 64'h1000, 64'h5A, 8'h01);
    wait_quiet();
    chk("write_first_byte", last_resp[7:0], 8'h5A);
    chk("write_first_data", last_resp, 64'hAABB_CCDD_0000_105A);

    // Store miss left in the buffer, then a load miss must drain it first.
    r0 = rd_cnt; w0 = wr_cnt;
    hold_mem = 1'b1;
    issue(0, '0, 1, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF);
    issue(1, 64'h2000, 0, '0, '0, '0);
    hold_mem = 1'b0;
    wait_quiet();
    chk("drain_writes", wr_cnt - w0, 1);
    chk("drain_reads", rd_cnt - r0, 8);
    chk("drain_data", last_resp, 64'h1122_3344_5566_7788);

    // Reset in the middle of a refill.
    c0 = resp_cnt; g0 = rsp_given; n = 0;
    issue(1, 64'h3000, 0, '0, '0, '0);
    while (rsp_given < g0 + 3 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) chk("refill_beats_timeout", 0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {ports.load_a_ready, ports.wready, ports.load_d_valid}, 3'b110);
    r0 = rd_cnt;
    issue(1, 64'h3000, 0, '0, '0, '0);
    wait_quiet();
    chk("reload_reads", rd_cnt - r0, 8);
    chk("reload_resps", resp_cnt - c0, 1);
    chk("reload_data", last_resp, 64'hD0D0_3000_0000_3000);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      la = rnd_addr();
      sa = ($urandom_range(0, 1) != 0) ? la : rnd_addr();
      if (kind <= 3) issue(1, la, 0, '0, '0, '0);
      else if (kind <= 6) issue(0, '0, 1, sa, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      else if (kind == 7) issue(1, la, 1, sa, {$urandom, $urandom}, 8'($urandom_range(1, 255)));
      else repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_quiet();
    chk("final_pending_reads", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 SHALL have parameter NR_LINES, default DCACHE_NR_LINES (64): number of direct-mapped lines, power of two.
REQ-002 SHALL have parameter LINE_BYTES, default CACHELINE_SIZE (64): line size in bytes, multiple of 8.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dcache_ports_io  modport  --  responder side of dcache_ports_if.
- Store fields: waddr 64, wdata 64, wmask 8, wvalid in; wready out.
- Load fields: load_a_addr 64, load_a_valid in; load_a_ready out; load_d_data 64, load_d_valid out.
REQ-006 mem_req_valid/mem_req_ready  out/in  1  request handshake to backing memory.
REQ-007 mem_req_we  out  1  write request when 1, read request when 0.
REQ-008 mem_req_addr  out  64  8-byte aligned address.
REQ-009 mem_req_wdata/mem_req_wmask  out  64/8  write data and byte mask.
REQ-010 mem_rsp_valid/mem_rsp_rdata  in  1/64  read response, in order, one per read, no backpressure.

Function
REQ-011 Cache organisation: direct-mapped, write-through, no-write-allocate; per-line valid bit, tag, LINE_BYTES of data.
REQ-012 Address split: offset = low log2(LINE_BYTES) bits, index = next log2(NR_LINES) bits, tag = remaining bits. Data path always operates on the aligned dword (addr[2:0] ignored).
REQ-013 FSM states: IDLE, DRAIN, REFILL_REQ, REFILL_WAIT, RESP.
REQ-014 load_a_ready = 1 only in IDLE. A load is accepted on load_a_valid && load_a_ready.
REQ-015 Hit on an accepted load: load_d_valid = 1 exactly 1 cycle after acceptance, for one cycle. load_d_data = the full aligned dword. FSM stays in IDLE.
REQ-016 Miss on an accepted load: the address is latched.
- If the write buffer is valid: go to DRAIN, then REFILL_REQ once the buffer is empty.
- Otherwise: go directly to REFILL_REQ.
REQ-017 REFILL_REQ issues a read for beat k (line base + 8k); it advances to REFILL_WAIT on mem_req_ready. REFILL_WAIT writes mem_rsp_rdata into beat k on mem_rsp_valid.
- If k < LINE_BYTES/8-1: increment k, return to REFILL_REQ.
- Otherwise: set valid and tag, go to RESP.
REQ-018 RESP drives load_d_valid = 1 for one cycle with the requested dword from the refilled line, then returns to IDLE. Miss latency = DRAIN time + 2*beats + 1 cycles minimum.
REQ-019 Store path has a 1-entry write buffer. wready = IDLE && !wbuf_valid. A store is accepted on wvalid && wready.
REQ-020 On an accepted store that hits: the array dword is updated byte-wise per wmask in the same cycle. A miss does not update the array. In both cases the store enters the write buffer.
REQ-021 The write buffer issues mem_req_valid with we=1 whenever valid and the FSM is not in REFILL_REQ/REFILL_WAIT. It clears on mem_req_ready and may accept a new store the following cycle.
REQ-022 Same-cycle load and store acceptance to the same dword: load_d_data SHALL reflect the store's masked bytes (write-first). A store to a different dword does not affect the load.
REQ-023 Only one memory request is outstanding at a time. mem_req_* is held stable while mem_req_valid && !mem_req_ready.
REQ-024 load_d_valid is never asserted without a prior accepted load. Exactly one response per accepted load.

Reset
REQ-025 While rst is high:
- State returns to IDLE; all line valid bits, wbuf_valid and the beat counter are cleared.
- Outputs: load_d_valid=0, mem_req_valid=0, load_a_ready=0, wready=0.
REQ-026 Reset asserted mid-refill or mid-drain abandons the operation. Memory responses arriving after reset are ignored. The first cycle after reset is IDLE with ready outputs high.
REQ-027 The data and tag arrays need no reset.

Structure
REQ-028 DCACHE_NR_LINES, CACHELINE_SIZE and the dcache_state_t enum SHALL live in the shared core package. The dcache_ports_if definition is reused unchanged.
REQ-029 Data storage SHALL be one sub-module, dcache_line_ram: 1 read port, 1 byte-masked dword write port, registered read.

Verification
REQ-030 Cold load 0x1000 -> 8 mem reads at 0x1000..0x1038 in order; load_d_valid once with the dword from 0x1000; load_a_ready low throughout.
REQ-031 Second load 0x1008 after refill -> load_d_valid 1 cycle after acceptance, no mem request.
REQ-032 Store 0x1004, wdata 0xAABBCCDD_00000000, wmask 0xF0 to a resident line -> one mem write (mask 0xF0); subsequent load 0x1000 returns upper word 0xAABBCCDD.
REQ-033 Store to 0x2000 (miss), then load 0x2000 miss -> mem write issued and completed before the first refill read; loaded data contains the stored bytes.
REQ-034 Same-cycle load 0x1000 + store 0x1000 mask 0x01 data 0x5A -> load_d_data[7:0]=0x5A.
REQ-035 rst asserted after beat 3 of a refill -> IDLE next cycle, no load_d_valid; reload of the same address performs a full 8-beat refill.
